// File: rtl/sat_adder_tree_pipe.sv
// ---------------------------------------------------------------------------
// sat_adder_tree_pipe
//
// Fully pipelined, parametrised saturating adder tree. It reduces N_IN signed
// lanes to one sum. An optional accumulation stage then folds ACC_LEN
// consecutive tree results into a single output. Each tree level is
// registered. A valid bit and a saturation flag travel with the data, so a
// consumer can tell whether any adder on the way clipped.
//
// Parameters
//   N_IN     number of input lanes (>= 2, any value, not only powers of two)
//   W        lane / sum / output width, signed two's complement
//   ACC_LEN  tree results accumulated per output (1 = no accumulation)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         pipeline enable; 0 freezes every register, including out_valid
//   clear      synchronous clear of data, valid, sat and count state
//   in_valid   in_data holds a valid vector this cycle
//   in_data    packed lanes, lane i = in_data[i*W +: W]
//   out_valid  one-enabled-cycle pulse when out_data/sat_flag are updated
//   out_data   saturated result, held until the next completion
//   sat_flag   some adder that contributed to out_data saturated
//   busy       a valid bit is set in a tree level, or an accumulation is open
//
// Latency is ceil(log2(N_IN)) tree levels plus one accumulator/output stage.
// ---------------------------------------------------------------------------
module sat_adder_tree_pipe #(
    parameter int N_IN    = 8,
    parameter int W       = 28,
    parameter int ACC_LEN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [N_IN*W-1:0] in_data,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              sat_flag,
    output logic              busy
);

    // Number of elements present at tree level k. Level 0 is the raw input.
    // Each level halves the count and rounds up, because an odd leftover
    // element passes through unchanged.
    function automatic int level_count(input int k);
        return (N_IN + (1 << k) - 1) >> k;
    endfunction

    // Index of the first element of level k in the flat node store.
    // Levels are laid out back to back, starting with level 0.
    function automatic int level_offset(input int k);
        int total;
        total = 0;
        for (int i = 0; i < k; i++) begin
            total += level_count(i);
        end
        return total;
    endfunction

    // Signed saturating add. Bit W of the result flags an overflow, and bits
    // W-1:0 hold the clipped or wrapped sum. Overflow is only possible when
    // both operands have the same sign and the wrapped sum has the other sign.
    function automatic logic [W:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] sum;
        logic         pos_ovf;
        logic         neg_ovf;
        sum     = a + b;
        pos_ovf = ~a[W-1] & ~b[W-1] &  sum[W-1];
        neg_ovf =  a[W-1] &  b[W-1] & ~sum[W-1];
        if (pos_ovf) begin
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        end else if (neg_ovf) begin
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, sum};
        end
    endfunction

    localparam int LEVELS     = $clog2(N_IN);
    localparam int TOTAL      = level_offset(LEVELS + 1);
    localparam int FINAL_OFF  = level_offset(LEVELS);
    localparam int CW         = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(ACC_LEN - 1);

    // Flat store of every tree node: data, sat bit, and one valid per level.
    // Level 0 is wired straight from the inputs. Each higher level is driven
    // by the registers created in the generate loop below.
    logic [TOTAL*W-1:0] node_data;
    logic [TOTAL-1:0]   node_sat;
    logic [LEVELS:0]    level_valid;

    assign node_data[N_IN*W-1:0] = in_data;
    assign node_sat[N_IN-1:0]    = '0;
    assign level_valid[0]        = in_valid;

    // One registered stage per tree level. Adjacent pairs of the previous
    // level are added with saturation. If the previous level has an odd
    // count, its last element is copied into the last slot of this level,
    // together with its sat bit.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int PREV_CNT = level_count(k - 1);
        localparam int CNT      = level_count(k);
        localparam int PREV_OFF = level_offset(k - 1);
        localparam int OFF      = level_offset(k);

        logic valid_q;

        // The valid bit of this level follows the previous level on every
        // enabled cycle. Reset and clear drop in-flight vectors.
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= level_valid[k-1];
            end
        end

        assign level_valid[k] = valid_q;

        for (genvar j = 0; j < CNT; j++) begin : g_node
            logic [W-1:0] data_q;
            logic         sat_q;

            if (2 * j + 1 < PREV_CNT) begin : g_pair
                logic [W:0] pair_sum;

                assign pair_sum = sat_add(node_data[(PREV_OFF + 2*j) * W +: W],
                                          node_data[(PREV_OFF + 2*j + 1) * W +: W]);

                // Pair adder register. It loads on every enabled cycle,
                // whether or not the data is valid. Invalid data is never
                // consumed downstream, so there is no need to gate the load.
                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        data_q <= '0;
                        sat_q  <= 1'b0;
                    end else if (en) begin
                        data_q <= pair_sum[W-1:0];
                        sat_q  <= pair_sum[W]
                                | node_sat[PREV_OFF + 2*j]
                                | node_sat[PREV_OFF + 2*j + 1];
                    end
                end
            end else begin : g_pass
                // Odd leftover element. It only needs a delay register to stay
                // aligned with its neighbours, and its sat history goes with it.
                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        data_q <= '0;
                        sat_q  <= 1'b0;
                    end else if (en) begin
                        data_q <= node_data[(PREV_OFF + 2*j) * W +: W];
                        sat_q  <= node_sat[PREV_OFF + 2*j];
                    end
                end
            end

            assign node_data[(OFF + j) * W +: W] = data_q;
            assign node_sat[OFF + j]             = sat_q;
        end
    end

    logic [W-1:0]  tree_data;
    logic          tree_sat;
    logic          tree_valid;

    assign tree_data  = node_data[FINAL_OFF * W +: W];
    assign tree_sat   = node_sat[FINAL_OFF];
    assign tree_valid = level_valid[LEVELS];

    logic [W-1:0]  acc;
    logic          acc_sat;
    logic [CW-1:0] count;
    logic [W:0]    acc_sum;
    logic [W-1:0]  acc_next;
    logic          acc_sat_next;

    assign acc_sum = sat_add(acc, tree_data);

    // Next accumulator value. The first result of a group replaces whatever
    // the accumulator held, so no explicit flush between groups is needed.
    // Later results are added with saturation, and the sticky sat flag
    // collects tree saturations as well as accumulator overflows.
    always_comb begin
        acc_next     = tree_data;
        acc_sat_next = tree_sat;
        if (count != '0) begin
            acc_next     = acc_sum[W-1:0];
            acc_sat_next = acc_sat | tree_sat | acc_sum[W];
        end
    end

    // Accumulation and output stage. When the last result of a group arrives,
    // the new value is published and out_valid pulses for one enabled cycle.
    // While en is low, out_valid holds its value like every other register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc       <= '0;
            acc_sat   <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            if (tree_valid) begin
                acc     <= acc_next;
                acc_sat <= acc_sat_next;
                if (count == LAST_COUNT) begin
                    count     <= '0;
                    out_valid <= 1'b1;
                    out_data  <= acc_next;
                    sat_flag  <= acc_sat_next;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // Busy covers vectors still in the tree and partially accumulated groups.
    assign busy = (|level_valid[LEVELS:1]) | (count != '0);

endmodule

// File: tb/tb_sat_adder_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_sat_adder_tree_pipe
//
// Directed bench for sat_adder_tree_pipe with three instances:
//   dut8  : N_IN=8, W=28, ACC_LEN=1  (latency 4)
//   dutacc: N_IN=8, W=28, ACC_LEN=4  (latency 4 after the 4th vector)
//   dut5  : N_IN=5, W=28, ACC_LEN=1  (odd lane count, latency 4)
// The three instances share clk, reset, en and clear. Each one has its own
// vector inputs.
// ---------------------------------------------------------------------------
module tb_sat_adder_tree_pipe;

    localparam int W = 28;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           clear;

    logic           in_valid8;
    logic [8*W-1:0] in_data8;
    logic           out_valid8;
    logic [W-1:0]   out_data8;
    logic           sat_flag8;
    logic           busy8;

    logic           in_valid_acc;
    logic [8*W-1:0] in_data_acc;
    logic           out_valid_acc;
    logic [W-1:0]   out_data_acc;
    logic           sat_flag_acc;
    logic           busy_acc;

    logic           in_valid5;
    logic [5*W-1:0] in_data5;
    logic           out_valid5;
    logic [W-1:0]   out_data5;
    logic           sat_flag5;
    logic           busy5;

    int checks = 0;
    int passed = 0;

    sat_adder_tree_pipe #(.N_IN(8), .W(W), .ACC_LEN(1)) dut8 (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .in_valid(in_valid8), .in_data(in_data8),
        .out_valid(out_valid8), .out_data(out_data8),
        .sat_flag(sat_flag8), .busy(busy8)
    );

    sat_adder_tree_pipe #(.N_IN(8), .W(W), .ACC_LEN(4)) dutacc (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .in_valid(in_valid_acc), .in_data(in_data_acc),
        .out_valid(out_valid_acc), .out_data(out_data_acc),
        .sat_flag(sat_flag_acc), .busy(busy_acc)
    );

    sat_adder_tree_pipe #(.N_IN(5), .W(W), .ACC_LEN(1)) dut5 (
        .clk(clk), .reset(reset), .en(en), .clear(clear),
        .in_valid(in_valid5), .in_data(in_data5),
        .out_valid(out_valid5), .out_data(out_data5),
        .sat_flag(sat_flag5), .busy(busy5)
    );

    always #5 clk = ~clk;

    // Advance one clock. Stimulus changes and checks happen 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // 8-lane vector that sums to s: lane0 = s, lane3 = -3, lane7 = +3.
    function automatic logic [8*W-1:0] vec8(input int s);
        logic [8*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(s);
        v[3*W +: W] = W'(-3);
        v[7*W +: W] = W'(3);
        return v;
    endfunction

    // Present one vector to dut8, then wait until its result is due.
    task automatic send8_wait(input logic [8*W-1:0] v);
        in_data8  = v;
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick;
        checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid8); else passed++;
        checks++; if (out_data8 !== '0) $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data8); else passed++;
        checks++; if (sat_flag8 !== 1'b0) $display("[TB] FAIL reset_sat_flag: got %b, expected 0", sat_flag8); else passed++;
        checks++; if (busy8 !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy8); else passed++;
        checks++; if (busy_acc !== 1'b0) $display("[TB] FAIL reset_busy_acc: got %b, expected 0", busy_acc); else passed++;
        reset = 1'b0;
        en    = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int early;
        early     = 0;
        in_data8  = {28'd8, 28'd7, 28'd6, 28'd5, 28'd4, 28'd3, 28'd2, 28'd1};
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        checks++; if (busy8 !== 1'b1) $display("[TB] FAIL basic_busy_inflight: got %b, expected 1", busy8); else passed++;
        for (int i = 0; i < 2; i++) begin
            tick;
            if (out_valid8 !== 1'b0) early++;
        end
        checks++; if (early != 0) $display("[TB] FAIL basic_early_pulse: got %0d early pulses, expected 0", early); else passed++;
        tick;
        checks++; if (out_valid8 !== 1'b1) $display("[TB] FAIL basic_out_valid: got %b, expected 1", out_valid8); else passed++;
        checks++; if (out_data8 !== 28'd36) $display("[TB] FAIL basic_out_data: got %0d, expected 36", $signed(out_data8)); else passed++;
        checks++; if (sat_flag8 !== 1'b0) $display("[TB] FAIL basic_sat_flag: got %b, expected 0", sat_flag8); else passed++;
        tick;
        checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL basic_pulse_width: got %b, expected 0", out_valid8); else passed++;
        checks++; if (busy8 !== 1'b0) $display("[TB] FAIL basic_busy_after: got %b, expected 0", busy8); else passed++;
        checks++; if (out_data8 !== 28'd36) $display("[TB] FAIL basic_data_hold: got %0d, expected 36", $signed(out_data8)); else passed++;
    endtask

    task automatic test_saturation;
        send8_wait({8{28'h7FFFFFF}});
        checks++; if (out_valid8 !== 1'b1) $display("[TB] FAIL satpos_valid: got %b, expected 1", out_valid8); else passed++;
        checks++; if (out_data8 !== 28'h7FFFFFF) $display("[TB] FAIL satpos_data: got %h, expected 7ffffff", out_data8); else passed++;
        checks++; if (sat_flag8 !== 1'b1) $display("[TB] FAIL satpos_flag: got %b, expected 1", sat_flag8); else passed++;
        tick;
        send8_wait({8{28'h8000000}});
        checks++; if (out_data8 !== 28'h8000000) $display("[TB] FAIL satneg_data: got %h, expected 8000000", out_data8); else passed++;
        checks++; if (sat_flag8 !== 1'b1) $display("[TB] FAIL satneg_flag: got %b, expected 1", sat_flag8); else passed++;
        tick;
        send8_wait({28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'hFFFFFFF, 28'h7FFFFFF});
        checks++; if (out_data8 !== 28'h7FFFFFE) $display("[TB] FAIL nosat_data: got %h, expected 7fffffe", out_data8); else passed++;
        checks++; if (sat_flag8 !== 1'b0) $display("[TB] FAIL nosat_flag: got %b, expected 0", sat_flag8); else passed++;
        tick;
    endtask

    task automatic test_back_to_back;
        int  sums[14] = '{0, -5, 100, -1000, 7, 123456, -77, 42, 1, 999, 0, 0, -31, 555};
        bit  pat[14]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        int  idx;
        logic expv;
        for (int c = 0; c < 19; c++) begin
            if (c < 14 && pat[c]) begin
                in_data8  = vec8(sums[c]);
                in_valid8 = 1'b1;
            end else begin
                in_valid8 = 1'b0;
            end
            tick;
            idx  = c - 3;
            expv = (idx >= 0 && idx < 14) ? pat[idx] : 1'b0;
            checks++; if (out_valid8 !== expv) $display("[TB] FAIL stream_valid[%0d]: got %b, expected %b", c, out_valid8, expv); else passed++;
            if (expv) begin
                checks++; if (out_data8 !== 28'(sums[idx])) $display("[TB] FAIL stream_data[%0d]: got %0d, expected %0d", idx, $signed(out_data8), sums[idx]); else passed++;
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_accumulate;
        logic [15:0]  mask[4]  = '{16'h008B, 16'h000F, 16'h000F, 16'h000F};
        int           sval[4]  = '{10, 5, 32'h4000000, 1};
        int           pulse[4] = '{10, 6, 6, 6};
        logic [W-1:0] edata[4] = '{28'd40, 28'd20, 28'h7FFFFFF, 28'd4};
        logic         esat[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         expv;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 16; c++) begin
                in_data_acc  = vec8(sval[p]);
                in_valid_acc = mask[p][c];
                tick;
                expv = (c == pulse[p]);
                checks++; if (out_valid_acc !== expv) $display("[TB] FAIL acc_valid[%0d][%0d]: got %b, expected %b", p, c, out_valid_acc, expv); else passed++;
                if (expv) begin
                    checks++; if (out_data_acc !== edata[p]) $display("[TB] FAIL acc_data[%0d]: got %h, expected %h", p, out_data_acc, edata[p]); else passed++;
                    checks++; if (sat_flag_acc !== esat[p]) $display("[TB] FAIL acc_sat[%0d]: got %b, expected %b", p, sat_flag_acc, esat[p]); else passed++;
                end
            end
        end
        in_valid_acc = 1'b0;
        checks++; if (busy_acc !== 1'b0) $display("[TB] FAIL acc_busy_idle: got %b, expected 0", busy_acc); else passed++;
    endtask

    task automatic test_stall;
        int early;
        early     = 0;
        in_data8  = {8{28'd3}};
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        tick;
        en        = 1'b0;
        in_data8  = {8{28'd100}};
        in_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (out_valid8 !== 1'b0) early++;
        end
        in_valid8 = 1'b0;
        en        = 1'b1;
        tick;
        if (out_valid8 !== 1'b0) early++;
        checks++; if (early != 0) $display("[TB] FAIL stall_early_pulse: got %0d early pulses, expected 0", early); else passed++;
        tick;
        checks++; if (out_valid8 !== 1'b1) $display("[TB] FAIL stall_valid: got %b, expected 1", out_valid8); else passed++;
        checks++; if (out_data8 !== 28'd24) $display("[TB] FAIL stall_data: got %0d, expected 24", $signed(out_data8)); else passed++;
        en = 1'b0;
        tick;
        checks++; if (out_valid8 !== 1'b1) $display("[TB] FAIL stall_valid_hold: got %b, expected 1", out_valid8); else passed++;
        en = 1'b1;
        tick;
        checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL stall_valid_drop: got %b, expected 0", out_valid8); else passed++;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (out_valid8 !== 1'b0) early++;
        end
        checks++; if (early != 0) $display("[TB] FAIL stall_ignored_input: got %0d pulses, expected 0", early); else passed++;
        checks++; if (busy8 !== 1'b0) $display("[TB] FAIL stall_busy: got %b, expected 0", busy8); else passed++;
    endtask

    task automatic test_clear;
        int spurious;
        in_data8  = vec8(77);
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        checks++; if (busy8 !== 1'b0) $display("[TB] FAIL clear_busy: got %b, expected 0", busy8); else passed++;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid8 !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) $display("[TB] FAIL clear_discard: got %0d pulses, expected 0", spurious); else passed++;

        in_data8  = vec8(55);
        in_valid8 = 1'b1;
        clear     = 1'b1;
        tick;
        in_valid8 = 1'b0;
        clear     = 1'b0;
        checks++; if (busy8 !== 1'b0) $display("[TB] FAIL clear_same_cycle_busy: got %b, expected 0", busy8); else passed++;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (out_valid8 !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) $display("[TB] FAIL clear_same_cycle_discard: got %0d pulses, expected 0", spurious); else passed++;
    endtask

    // Opens an accumulation with two results, aborts it with clear or reset,
    // then checks that the next group of four starts again from count 0.
    task automatic acc_abort(input bit use_reset);
        logic expv;
        in_data_acc  = vec8(10);
        in_valid_acc = 1'b1;
        repeat (2) tick;
        in_valid_acc = 1'b0;
        repeat (4) tick;
        checks++; if (busy_acc !== 1'b1) $display("[TB] FAIL abort%0d_busy_open: got %b, expected 1", use_reset, busy_acc); else passed++;
        if (use_reset) reset = 1'b1; else clear = 1'b1;
        tick;
        reset = 1'b0;
        clear = 1'b0;
        checks++; if (busy_acc !== 1'b0) $display("[TB] FAIL abort%0d_busy: got %b, expected 0", use_reset, busy_acc); else passed++;
        for (int c = 0; c < 10; c++) begin
            in_valid_acc = (c < 4);
            tick;
            expv = (c == 6);
            checks++; if (out_valid_acc !== expv) $display("[TB] FAIL abort%0d_valid[%0d]: got %b, expected %b", use_reset, c, out_valid_acc, expv); else passed++;
            if (expv) begin
                checks++; if (out_data_acc !== 28'd40) $display("[TB] FAIL abort%0d_data: got %0d, expected 40", use_reset, $signed(out_data_acc)); else passed++;
            end
        end
        in_valid_acc = 1'b0;
    endtask

    task automatic test_clear_mid_acc;
        acc_abort(1'b0);
    endtask

    task automatic test_reset_mid_acc;
        acc_abort(1'b1);
    endtask

    task automatic test_odd_lanes;
        int early;
        early     = 0;
        in_data5  = {28'd5, 28'd4, 28'd3, 28'd2, 28'd1};
        in_valid5 = 1'b1;
        tick;
        in_valid5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            if (out_valid5 !== 1'b0) early++;
        end
        checks++; if (early != 0) $display("[TB] FAIL odd_early_pulse: got %0d, expected 0", early); else passed++;
        tick;
        checks++; if (out_valid5 !== 1'b1) $display("[TB] FAIL odd_valid: got %b, expected 1", out_valid5); else passed++;
        checks++; if (out_data5 !== 28'd15) $display("[TB] FAIL odd_data: got %0d, expected 15", $signed(out_data5)); else passed++;
        checks++; if (sat_flag5 !== 1'b0) $display("[TB] FAIL odd_sat: got %b, expected 0", sat_flag5); else passed++;
        tick;
        in_data5  = {28'd1, 28'd0, 28'd0, 28'd0, 28'h7FFFFFF};
        in_valid5 = 1'b1;
        tick;
        in_valid5 = 1'b0;
        repeat (3) tick;
        checks++; if (out_valid5 !== 1'b1) $display("[TB] FAIL oddsat_valid: got %b, expected 1", out_valid5); else passed++;
        checks++; if (out_data5 !== 28'h7FFFFFF) $display("[TB] FAIL oddsat_data: got %h, expected 7ffffff", out_data5); else passed++;
        checks++; if (sat_flag5 !== 1'b1) $display("[TB] FAIL oddsat_flag: got %b, expected 1", sat_flag5); else passed++;
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        clear        = 1'b0;
        in_valid8    = 1'b0;
        in_data8     = '0;
        in_valid_acc = 1'b0;
        in_data_acc  = '0;
        in_valid5    = 1'b0;
        in_data5     = '0;

        test_reset;
        test_basic;
        test_saturation;
        test_back_to_back;
        test_accumulate;
        test_stall;
        test_clear;
        test_clear_mid_acc;
        test_reset_mid_acc;
        test_odd_lanes;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sat_adder_tree_pipe.md
Name: sat_adder_tree_pipe

Overview:
Parametrised, fully pipelined saturating adder tree. It reduces N_IN signed lanes, typically MAC outputs, to a single sum. An optional accumulation stage then sums ACC_LEN consecutive tree results into one output. It sits between the MAC array and the output/activation stage of the 1D convolution datapath, and replaces fixed 8-input reduction trees. A valid bit and a saturation flag travel through the pipeline with the data.

Parameters:
N_IN, 8, number of input lanes (>= 2; need not be a power of two)
W, 28, lane, sum and output width in bits, signed two's complement
ACC_LEN, 1, number of tree results accumulated per output (>= 1; 1 = no accumulation)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  pipeline enable; 0 freezes every register in the block
clear  input  1  synchronous clear of all data, valid, flag and count state
in_valid  input  1  in_data carries a valid vector this cycle
in_data  input  N_IN*W  packed lanes; lane i = in_data[i*W +: W]
out_valid  output  1  out_data/sat_flag carry a completed result
out_data  output  W  saturated sum (signed)
sat_flag  output  1  saturation occurred in any adder contributing to out_data
busy  output  1  any valid bit set in the tree pipeline, or accumulation count != 0

Behaviour:
- L = ceil(log2(N_IN)) tree levels; every level is registered. Total latency = L+1 enabled cycles from in_valid sample to out_valid.
- Level k pairs adjacent elements (0+1, 2+3, ...). An odd leftover element is registered unchanged into the next level, in the last position.
- Saturating add of a and b:
  - if a >= 0, b >= 0 and the wrapped sum < 0, the result is 2^(W-1)-1;
  - if a < 0, b < 0 and the wrapped sum >= 0, the result is -2^(W-1);
  - otherwise the result is the wrapped W-bit sum.
- Per-element sat bit: OR of both operand sat bits and the current add's overflow. Level-0 inputs carry sat = 0.
- Valid bit per level shifts alongside the data. Data registers load on every enabled cycle; values with valid = 0 are don't-care, but an accumulator never consumes them.
- Accumulation stage, on an enabled cycle with tree-final valid:
  - if count == 0: acc <= tree sum, accsat <= tree sat;
  - otherwise: acc <= sat_add(acc, tree sum), accsat <= accsat | tree sat | overflow.
  - If count == ACC_LEN-1: out_data and sat_flag <= the new acc/accsat value, out_valid <= 1, count <= 0.
  - Otherwise count <= count+1.
- With ACC_LEN = 1, every tree result produces out_valid, one cycle after tree-final valid.
- out_valid is a one-cycle pulse measured in enabled cycles. It is cleared on the next enabled cycle without a new completion.
- out_data and sat_flag hold their last value until the next completion.
- en = 0: all registers hold, including out_valid. Consumers qualify out_valid with en. in_valid is ignored while en = 0.
- reset or clear: all data, valid, sat bits, acc and count go to 0. Outputs reset to out_valid = 0, out_data = 0, sat_flag = 0, busy = 0. Priority: reset = clear > en. In-flight vectors are discarded and no out_valid is produced for them.
- A vector presented in the same cycle as clear is discarded.
- Back-to-back in_valid on consecutive enabled cycles is fully supported at a throughput of 1 vector per cycle.
- Count width = max(1, ceil(log2(ACC_LEN))).

Test Plan:
- N_IN=8, W=28, ACC_LEN=1: lanes = 1..8, in_valid for one cycle, en=1 -> out_valid pulses exactly 4 cycles later, out_data = 36, sat_flag = 0, busy = 0 afterwards.
- Saturation: all lanes = 0x7FFFFFF -> out_data = 0x7FFFFFF, sat_flag = 1. All lanes = 0x8000000 -> out_data = 0x8000000, sat_flag = 1. Lanes {0x7FFFFFF, -1, 0, ...} -> out_data = 0x7FFFFFE, sat_flag = 0.
- Streaming: 10 consecutive valid vectors with sums 0, -5, 100, ... -> 10 consecutive out_valid pulses in order with matching sums. A gap in in_valid produces a matching gap in out_valid.
- ACC_LEN=4: four vectors each summing to 10, with 0-3 idle cycles between them -> exactly one out_valid, 1 cycle after the 4th tree result, with out_data = 40. A fifth vector starts a new accumulation.
- Stall and clear: drop en for 3 cycles while a vector is mid-tree -> the result arrives exactly 3 cycles late with its value unchanged. Assert clear mid-tree -> no out_valid for that vector, busy = 0 the next cycle, and the next accumulation starts at count 0. reset mid-accumulation behaves identically.
- N_IN=5 (L=3): lanes = 1,2,3,4,5 -> out_data = 15 after 4 cycles. Lanes = {0x7FFFFFF, 0, 0, 0, 1} -> out_data = 0x7FFFFFF, sat_flag = 1, which checks that the odd-lane pass-through path saturates correctly.
